// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready output buffer with frame-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_DIV = BAUD_DIV / 2;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IDX_W    = 3;

  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  logic [1:0]        sync_q;
  logic              rx_s;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d;
  logic              frame_err_d;
  logic              overrun_d;
  logic              tick_c;
  logic              deliver_c;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s   = sync_q[1];
  assign tick_c = (baud_cnt_q == '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data       <= data_d;
      valid      <= valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
    end
  end

  // Next-state, sampling and delivery decisions.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = tick_c ? baud_cnt_q : baud_cnt_q - CNT_W'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_c   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          baud_cnt_d = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (tick_c) begin
          if (!rx_s) begin
            state_d    = ST_DATA;
            baud_cnt_d = FULL_RELOAD;
            bit_idx_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick_c) begin
          shift_d    = {rx_s, shift_q[DATA_W-1:1]};
          baud_cnt_d = FULL_RELOAD;
          bit_idx_d  = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick_c) begin
          if (rx_s) begin
            deliver_c = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // Held-low line must return high before a new start bit is armed.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Single-entry output buffer; a byte arriving while full is dropped.
  always_comb begin
    data_d    = data;
    valid_d   = valid;
    overrun_d = 1'b0;

    if (valid && ready) begin
      valid_d = 1'b0;
    end

    if (deliver_c) begin
      if (!valid || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; a negedge monitor scores
// every valid&&ready handshake against a queue of expected bytes.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         pop_cnt = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         valid_rise_cyc = -1;
  logic       valid_prev = 1'b0;

  uart_rx #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: score handshakes, count flag pulses, record valid rise time.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (frame_err || overrun) begin
        checks++;
        if (frame_err && overrun) begin
          errors++;
          $display("FAIL flags_exclusive: frame_err=%0b overrun=%0b, required not both", frame_err, overrun);
        end
      end
      if (valid && !valid_prev) valid_rise_cyc = cyc;
      if (valid && ready) begin
        checks++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, required no delivery", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            errors++;
            $display("FAIL byte_data: got %02h, required %02h", data, e);
          end
        end
      end
    end
    valid_prev = valid;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Drive ncyc cycles of an 8N1 frame; pulse_at >= 0 drives ready high only in that cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pulse_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #2;
      if (c == 0) start_cyc = cyc;
      if (c < 10)      rx = 1'b0;
      else if (c < 90) rx = b[3'((c - 10) / 10)];
      else             rx = stop;
      if (pulse_at >= 0) ready = (c == pulse_at);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_f, base_o, base_p;

    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", int'(data), 0);
    check("reset_valid", int'(valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    idle(5);

    // Single byte with latency check (stop sample + 1 cycle, incl. 2-flop sync).
    base_f = ferr_cnt; base_o = ovr_cnt; base_p = pop_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1, 100);
    wait_drain("single_drain");
    check("single_latency", valid_rise_cyc - start_cyc, 98);
    idle(10);
    check("single_pops", pop_cnt - base_p, 1);
    check("single_no_ferr", ferr_cnt - base_f, 0);
    check("single_no_ovr", ovr_cnt - base_o, 0);

    // Back-to-back frames with no idle gap.
    base_p = pop_cnt;
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h5A);
    send_frame(8'h00, 1'b1, -1, 100);
    send_frame(8'hFF, 1'b1, -1, 100);
    send_frame(8'h5A, 1'b1, -1, 100);
    wait_drain("b2b_drain");
    idle(10);
    check("b2b_pops", pop_cnt - base_p, 3);

    // Short glitch: rejected at the mid-start recheck.
    base_f = ferr_cnt; base_p = pop_cnt;
    @(posedge clk); #2 rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    check("glitch_pops", pop_cnt - base_p, 0);
    check("glitch_ferr", ferr_cnt - base_f, 0);

    // Framing error then line held low.
    base_f = ferr_cnt; base_p = pop_cnt;
    send_frame(8'h3C, 1'b0, -1, 100);
    idle(50);
    rx = 1'b1;
    idle(20);
    check("frame_err_pulses", ferr_cnt - base_f, 1);
    check("frame_err_pops", pop_cnt - base_p, 0);

    // Overrun: second byte dropped while the first is pending.
    base_o = ovr_cnt;
    @(posedge clk); #2 ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, 100);
    send_frame(8'h22, 1'b1, -1, 100);
    idle(5);
    @(negedge clk);
    check("ovr_valid_held", int'(valid), 1);
    check("ovr_data_held", int'(data), 'h11);
    check("ovr_pulses", ovr_cnt - base_o, 1);
    @(posedge clk); #2 ready = 1'b1;
    @(posedge clk); #2 ready = 1'b0;
    wait_drain("ovr_drain");
    @(negedge clk);
    check("ovr_valid_cleared", int'(valid), 0);

    // Accept of the pending byte coincides with delivery of the next.
    base_o = ovr_cnt;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, -1, 100);
    send_frame(8'h22, 1'b1, 97, 100);
    idle(3);
    @(negedge clk);
    check("simul_valid", int'(valid), 1);
    check("simul_data", int'(data), 'h22);
    check("simul_no_ovr", ovr_cnt - base_o, 0);
    check("simul_queue", exp_q.size(), 1);
    @(posedge clk); #2 ready = 1'b1;
    wait_drain("simul_drain");

    // Reset during data bit 4, then a clean frame.
    base_f = ferr_cnt; base_p = pop_cnt;
    send_frame(8'hC3, 1'b1, -1, 55);
    @(posedge clk); #2 rst = 1'b1; rx = 1'b1;
    @(negedge clk);
    check("rst_mid_data", int'(data), 0);
    check("rst_mid_valid", int'(valid), 0);
    check("rst_mid_frame_err", int'(frame_err), 0);
    check("rst_mid_overrun", int'(overrun), 0);
    idle(3);
    rst = 1'b0;
    idle(3);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1, 100);
    wait_drain("rst_drain");
    idle(10);
    check("rst_pops", pop_cnt - base_p, 1);
    check("rst_no_ferr", ferr_cnt - base_f, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the board UART link. Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the asynchronous serial input. Each byte goes out on a valid/ready stream port to the command/control logic. Matches the line format of the team's UART transmitter, so the two can be looped back directly.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in bit/s
- Derived constants, not overridable:
  - BAUD_DIV = CLK_FREQ / BAUD_RATE (integer division)
  - HALF_DIV = BAUD_DIV / 2
  - Legal range: 4 ≤ BAUD_DIV ≤ 65535
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  8  received byte, held stable while valid=1
- valid  output  1  data holds an unconsumed byte
- ready  input  1  consumer accepts data when valid&&ready on a rising edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: completed byte dropped because the output was still full

## Operation
- **Synchronizer:** rx passes through a 2-flop synchronizer to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- **Counters:**
  - 16-bit down-counter baud_cnt; an event fires when baud_cnt==0.
  - 3-bit bit_idx.
  - 8-bit shift register, filled MSB-in and right-shifted, so the first received bit ends in bit 0.
- **State machine:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when rx_s==0, go to START with baud_cnt=HALF_DIV-1.
  - START: when baud_cnt==0, recheck rx_s at mid start bit.
    - rx_s==0: go to DATA with baud_cnt=BAUD_DIV-1 and bit_idx=0.
    - rx_s==1: treat as a glitch and return to IDLE. No flags.
  - DATA: when baud_cnt==0, shift in rx_s, reload baud_cnt=BAUD_DIV-1, and increment bit_idx. When bit_idx==7 at that event, go to STOP.
  - STOP: when baud_cnt==0, sample rx_s.
    - rx_s==1: deliver the byte (see Output buffer) and go to IDLE.
    - rx_s==0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait for rx_s==1, then go to IDLE. This prevents a held-low line or break condition from producing 0x00 bytes.
- **Output buffer (1 entry):**
  - On delivery, with valid=0 or (valid&&ready) in the same cycle: data is loaded with the new byte and valid=1.
  - On delivery with valid=1 and ready=0: the new byte is dropped, data is unchanged, and overrun pulses.
  - With no delivery, valid&&ready clears valid.
  - data changes only on a load.
- **Reception timing:** reception continues regardless of ready; the line is never stalled.
- **Reset mid-frame:** all state returns to reset values immediately (asynchronous). The partial byte is lost. After release, reception resumes at the next falling edge seen in IDLE. If the line is low at release, that low is treated as a start bit.

## Timing
- **Reset values:** data=0x00, valid=0, frame_err=0, overrun=0, state IDLE, baud_cnt=0, bit_idx=0, synchronizer flops=1.
- **Sample points**, relative to the first cycle rx_s==0 is seen in IDLE (cycle T):
  - Start check at T+HALF_DIV.
  - Data bit k sampled at T+HALF_DIV+(k+1)*BAUD_DIV, for k=0..7.
  - Stop bit sampled at T+HALF_DIV+9*BAUD_DIV.
- **valid rise:** valid (or a pulse flag) goes high in the cycle after the stop sample.
- **Input latency:** 2 cycles of synchronizer latency from a pin edge to rx_s.
- **Back-to-back frames:** IDLE is re-entered immediately after a good stop sample, so a start bit arriving half a bit later is accepted. No inter-frame gap is required beyond the stop bit.
- **Pulse flags:** frame_err and overrun are high for exactly one cycle per event and never high in the same cycle as each other.
- **Handshake rules:** ready may be held high permanently. valid never depends combinationally on ready.

## Test plan
Use CLK_FREQ=1000000 and BAUD_RATE=100000, giving BAUD_DIV=10 and HALF_DIV=5.

- **Single byte:** drive 0xA5 as a 10-cycle-per-bit frame with ready=1. Required: valid=1 for one cycle with data=0xA5; frame_err=0 and overrun=0 throughout.
- **Back-to-back bytes:** send 0x00, 0xFF, 0x5A with no idle gap and ready=1. Required: three valid pulses with data 0x00, 0xFF, 0x5A in order.
- **Glitch and framing error:**
  - A 3-cycle low pulse on rx produces no valid and no flags.
  - A frame for 0x3C with the stop bit driven low produces one frame_err pulse, no valid, and no further bytes while rx is held low for 50 cycles.
- **Overrun:** with ready=0, send 0x11 then 0x22. Required: data stays 0x11 with valid=1, and one overrun pulse at the end of the second frame. Raising ready for 1 cycle then clears valid.
- **Simultaneous accept and deliver:** hold 0x11 pending with ready=0. Pulse ready=1 exactly in the cycle the 0x22 stop bit is accepted. Required: data=0x22, valid stays 1, no overrun.
- **Reset mid-frame:** assert rst during data bit 4 of 0xC3, then release with rx=1 and send 0x81. Required:
  - All outputs at reset values during rst.
  - Only 0x81 is delivered after release.
  - No frame_err.
